wb_port_arbiter: RTL and testbench

- Owns the single register-file write port downstream of the write-back stage.
- Shares that port between two requesters:
  - the in-order pipeline write-back result, which has priority;
  - a long-latency multi-cycle unit (multiplier / late memory return), whose results are buffered in a small FIFO.
- Keeps a per-register pending scoreboard that stalls decode on hazards against in-flight multi-cycle results.
- Forces a one-cycle pipeline hold when the multi-cycle path is starved.

---
 rtl/wb_arb_pkg.sv | 17 +
 rtl/wb_port_arbiter_if.sv | 45 ++++
 rtl/wb_result_fifo.sv | 44 ++++
 rtl/wb_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and width defaults for the register-file write-port arbiter.
package wb_arb_pkg;

  localparam int unsigned DATA_W_DEF = 24;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    HOLD   = 1'b1
  } arb_state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between decode / write-back / multi-cycle unit and the write-port arbiter.
interface wb_port_arbiter_if
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) ();

  logic                     pipe_we;
  logic [ADDR_W-1:0]        pipe_addr;
  logic [DATA_W-1:0]        pipe_data;
  logic                     mc_valid;
  logic [ADDR_W-1:0]        mc_addr;
  logic [DATA_W-1:0]        mc_data;
  logic                     mc_ready;
  logic                     issue_valid;
  logic [ADDR_W-1:0]        issue_addr;
  logic [ADDR_W-1:0]        chk_a;
  logic [ADDR_W-1:0]        chk_b;
  logic [ADDR_W-1:0]        chk_d;
  logic                     stall;
  logic                     pipe_hold;
  logic                     rf_we;
  logic [ADDR_W-1:0]        rf_addr;
  logic [DATA_W-1:0]        rf_data;
  logic [(1<<ADDR_W)-1:0]   pending;
  logic                     err_collision;

  modport slave (
    input  pipe_we, pipe_addr, pipe_data,
    input  mc_valid, mc_addr, mc_data,
    input  issue_valid, issue_addr, chk_a, chk_b, chk_d,
    output mc_ready, stall, pipe_hold,
    output rf_we, rf_addr, rf_data, pending, err_collision
  );

  modport master (
    output pipe_we, pipe_addr, pipe_data,
    output mc_valid, mc_addr, mc_data,
    output issue_valid, issue_addr, chk_a, chk_b, chk_d,
    input  mc_ready, stall, pipe_hold,
    input  rf_we, rf_addr, rf_data, pending, err_collision
  );

endinterface

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO buffering multi-cycle results; pointers carry an extra wrap bit.
module wb_result_fifo
  import wb_arb_pkg::*;
#(
  parameter type         T     = wb_req_t,
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_head,
  output logic o_full,
  output logic o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  T            r_mem [DEPTH];
  logic [PW:0] r_wr;
  logic [PW:0] r_rd;

  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[PW] != r_rd[PW]) && (r_wr[PW-1:0] == r_rd[PW-1:0]);
  assign o_head  = r_mem[r_rd[PW-1:0]];

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr[PW-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline write-back has priority over buffered
// multi-cycle results; tracks pending destinations and forces a hold on starvation.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);

  localparam int unsigned NREG  = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t w_push_req;
  req_t w_head;
  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_push_req   = '{addr: bus.mc_addr, data: bus.mc_data};
  assign w_push       = bus.mc_valid & ~w_full;
  assign w_pop        = ~bus.pipe_we & ~w_empty;
  assign bus.mc_ready = ~w_full;

  wb_result_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_data;

  // Address/data hold their last value on idle cycles; only rf_we qualifies them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= bus.pipe_we | w_pop;
      if (bus.pipe_we) begin
        r_rf_addr <= bus.pipe_addr;
        r_rf_data <= bus.pipe_data;
      end else if (w_pop) begin
        r_rf_addr <= w_head.addr;
        r_rf_data <= w_head.data;
      end
    end
  end

  assign bus.rf_we   = r_rf_we;
  assign bus.rf_addr = r_rf_addr;
  assign bus.rf_data = r_rf_data;

  logic [NREG-1:0] r_pending;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_clr;

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (bus.issue_valid) w_set[bus.issue_addr] = 1'b1;
    if (w_pop)           w_clr[w_head.addr]    = 1'b1;
  end

  // Set applied after clear so a same-cycle issue to the retiring register wins.
  always_ff @(posedge clk) begin
    if (rst) r_pending <= '0;
    else     r_pending <= (r_pending & ~w_clr) | w_set;
  end

  assign bus.pending = r_pending;
  assign bus.stall   = r_pending[bus.chk_a] | r_pending[bus.chk_b] | r_pending[bus.chk_d];

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_starve;
  logic [CNT_W-1:0] w_starve_nxt;
  logic             w_starve_inc;
  logic             w_pipe_hold;
  logic             r_err;

  assign w_starve_inc = ~w_empty & bus.pipe_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= NORMAL;
      r_starve <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      r_err    <= r_err | (bus.pipe_we & w_pipe_hold);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    unique case (r_state)
      NORMAL: begin
        if (w_starve_inc) begin
          if (r_starve == CNT_W'(STARVE_MAX - 1)) w_state_nxt = HOLD;
          if (r_starve != CNT_W'(STARVE_MAX))     w_starve_nxt = r_starve + 1'b1;
        end else begin
          w_starve_nxt = '0;
        end
      end
      HOLD: begin
        w_state_nxt  = NORMAL;
        w_starve_nxt = '0;
      end
    endcase
  end

  always_comb begin
    w_pipe_hold = (r_state == HOLD);
  end

  assign bus.pipe_hold     = w_pipe_hold;
  assign bus.err_collision = r_err;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus randomized traffic against a queue-based model.
module tb_wb_port_arbiter;
  import wb_arb_pkg::*;

  localparam int DW    = 24;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int SMAX  = 8;
  localparam int NREG  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  wb_port_arbiter #(
    .DATA_W     (DW),
    .ADDR_W     (AW),
    .FIFO_DEPTH (DEPTH),
    .STARVE_MAX (SMAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t            q[$];
  logic [NREG-1:0] m_pend;
  int              m_lost;
  bit              m_hold;
  bit              m_err;
  logic            m_we;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_data;

  int checks = 0;
  int errors = 0;

  task automatic idle();
    bus.pipe_we     = 1'b0;
    bus.pipe_addr   = '0;
    bus.pipe_data   = '0;
    bus.mc_valid    = 1'b0;
    bus.mc_addr     = '0;
    bus.mc_data     = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
    bus.chk_a       = '0;
    bus.chk_b       = '0;
    bus.chk_d       = '0;
  endtask

  // Advances one clock; the model applies the write-port rules to the inputs present at the edge.
  task automatic tick();
    bit              pop, push, do_rst, n_hold, n_err;
    ent_t            head, nw;
    logic            n_we;
    logic [AW-1:0]   n_addr;
    logic [DW-1:0]   n_data;
    logic [NREG-1:0] n_pend;
    int              n_lost;
    do_rst = (rst === 1'b1);
    pop    = !bus.pipe_we && (q.size() > 0);
    push   = bus.mc_valid && (q.size() < DEPTH);
    head.a = '0;
    head.d = '0;
    if (pop) head = q[0];
    nw.a = bus.mc_addr;
    nw.d = bus.mc_data;
    n_we = 1'b0; n_addr = m_addr; n_data = m_data;
    if (bus.pipe_we) begin
      n_we = 1'b1; n_addr = bus.pipe_addr; n_data = bus.pipe_data;
    end else if (pop) begin
      n_we = 1'b1; n_addr = head.a; n_data = head.d;
    end
    n_pend = m_pend;
    if (pop) n_pend[head.a] = 1'b0;
    if (bus.issue_valid) n_pend[bus.issue_addr] = 1'b1;
    if (m_hold) begin
      n_hold = 1'b0; n_lost = 0;
    end else if (q.size() > 0 && bus.pipe_we) begin
      if (m_lost + 1 == SMAX) begin n_hold = 1'b1; n_lost = 0; end
      else begin n_hold = 1'b0; n_lost = m_lost + 1; end
    end else begin
      n_hold = 1'b0; n_lost = 0;
    end
    n_err = m_err | (bus.pipe_we & m_hold);
    @(posedge clk);
    #1;
    if (do_rst) begin
      q.delete();
      m_pend = '0; m_lost = 0; m_hold = 1'b0; m_err = 1'b0;
      m_we = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(nw);
      m_pend = n_pend; m_lost = n_lost; m_hold = n_hold; m_err = n_err;
      m_we = n_we; m_addr = n_addr; m_data = n_data;
    end
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %b exp 0", bus.rf_we); end
    checks++; if (bus.rf_addr !== 4'h0 || bus.rf_data !== 24'h0) begin errors++; $display("FAIL reset_rf_addr_data got %h/%h exp 0/0", bus.rf_addr, bus.rf_data); end
    checks++; if (bus.pending !== 16'h0) begin errors++; $display("FAIL reset_pending got %h exp 0", bus.pending); end
    checks++; if (bus.mc_ready !== 1'b1) begin errors++; $display("FAIL reset_mc_ready got %b exp 1", bus.mc_ready); end
    checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL reset_pipe_hold got %b exp 0", bus.pipe_hold); end
    checks++; if (bus.err_collision !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", bus.err_collision); end
  endtask

  task automatic test_pipe_only();
    idle(); tick();
    bus.pipe_we = 1'b1; bus.pipe_addr = 4'd3; bus.pipe_data = 24'h00ABCD;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 4'd3 || bus.rf_data !== 24'h00ABCD) begin
      errors++; $display("FAIL pipe_write got we=%b %h/%h exp 1 3/00abcd", bus.rf_we, bus.rf_addr, bus.rf_data); end
    idle(); tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL pipe_idle got %b exp 0", bus.rf_we); end
  endtask

  task automatic test_multicycle();
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = 4'd7; tick();
    idle();
    checks++; if (bus.pending[7] !== 1'b1) begin errors++; $display("FAIL mc_pending_set got %b exp 1", bus.pending[7]); end
    bus.chk_a = 4'd7; #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL mc_stall_raw got %b exp 1", bus.stall); end
    tick(); tick();
    bus.mc_valid = 1'b1; bus.mc_addr = 4'd7; bus.mc_data = 24'h123456;
    tick();
    bus.mc_valid = 1'b0;
    checks++; if (bus.rf_we !== 1'b0 || bus.pending[7] !== 1'b1) begin
      errors++; $display("FAIL mc_accept_cycle got we=%b pend=%b exp 0/1", bus.rf_we, bus.pending[7]); end
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 4'd7 || bus.rf_data !== 24'h123456) begin
      errors++; $display("FAIL mc_write got we=%b %h/%h exp 1 7/123456", bus.rf_we, bus.rf_addr, bus.rf_data); end
    checks++; if (bus.pending[7] !== 1'b0) begin errors++; $display("FAIL mc_pending_clr got %b exp 0", bus.pending[7]); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL mc_stall_drop got %b exp 0", bus.stall); end
  endtask

  task automatic test_conflict();
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = 4'd5; tick();
    idle();
    bus.mc_valid = 1'b1; bus.mc_addr = 4'd5; bus.mc_data = 24'h55AA55;
    bus.pipe_we = 1'b1; bus.pipe_addr = 4'd9; bus.pipe_data = 24'h090909;
    tick();
    checks++; if (bus.rf_addr !== 4'd9 || bus.rf_data !== 24'h090909) begin
      errors++; $display("FAIL conflict_pipe_first got %h/%h exp 9/090909", bus.rf_addr, bus.rf_data); end
    bus.mc_valid = 1'b0; bus.pipe_addr = 4'd10; bus.pipe_data = 24'h0A0A0A;
    tick();
    checks++; if (bus.rf_addr !== 4'd10 || bus.pending[5] !== 1'b1) begin
      errors++; $display("FAIL conflict_pipe_again got addr=%h pend5=%b exp a/1", bus.rf_addr, bus.pending[5]); end
    bus.pipe_we = 1'b0;
    tick();
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 4'd5 || bus.rf_data !== 24'h55AA55 || bus.pending[5] !== 1'b0) begin
      errors++; $display("FAIL conflict_fifo_drain got we=%b %h/%h pend5=%b exp 1 5/55aa55 0",
                         bus.rf_we, bus.rf_addr, bus.rf_data, bus.pending[5]); end
  endtask

  task automatic test_starvation();
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = 4'd4; tick();
    idle(); bus.mc_valid = 1'b1; bus.mc_addr = 4'd4; bus.mc_data = 24'h444444; tick();
    idle();
    for (int k = 1; k <= SMAX; k++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 4'd1; bus.pipe_data = DW'(k);
      tick();
      checks++; if (bus.pipe_hold !== (k == SMAX)) begin
        errors++; $display("FAIL starve_hold_k%0d got %b exp %b", k, bus.pipe_hold, (k == SMAX)); end
    end
    bus.pipe_we = 1'b0;
    tick();
    checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL starve_hold_one_cycle got %b exp 0", bus.pipe_hold); end
    checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== 4'd4 || bus.rf_data !== 24'h444444 || bus.pending[4] !== 1'b0) begin
      errors++; $display("FAIL starve_drain got we=%b %h/%h pend4=%b exp 1 4/444444 0",
                         bus.rf_we, bus.rf_addr, bus.rf_data, bus.pending[4]); end
    bus.mc_valid = 1'b1; bus.mc_addr = 4'd6; bus.mc_data = 24'h666666; tick();
    bus.mc_valid = 1'b0;
    for (int k = 1; k < SMAX; k++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 4'd1; bus.pipe_data = DW'(k); tick();
    end
    checks++; if (bus.pipe_hold !== 1'b0) begin errors++; $display("FAIL starve_below_max got %b exp 0", bus.pipe_hold); end
    bus.pipe_we = 1'b0; tick();
    checks++; if (bus.rf_addr !== 4'd6 || bus.rf_data !== 24'h666666) begin
      errors++; $display("FAIL starve_second_drain got %h/%h exp 6/666666", bus.rf_addr, bus.rf_data); end
  endtask

  task automatic test_full();
    logic [AW-1:0] ea[4];
    logic [DW-1:0] ed[4];
    ea = '{4'd3, 4'd4, 4'd6, 4'd7};
    ed = '{24'hF00002, 24'hF00003, 24'hF00005, 24'hF00006};
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 4'd0; bus.pipe_data = DW'(i);
      bus.mc_valid = 1'b1; bus.mc_addr = AW'(i + 1); bus.mc_data = 24'hF00000 + DW'(i);
      tick();
    end
    checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", bus.mc_ready); end
    bus.pipe_we = 1'b0; bus.mc_addr = 4'd5; bus.mc_data = 24'hF00004;
    tick();
    checks++; if (bus.rf_addr !== 4'd1 || bus.rf_data !== 24'hF00000 || bus.mc_ready !== 1'b1) begin
      errors++; $display("FAIL full_pop got %h/%h rdy=%b exp 1/f00000 1", bus.rf_addr, bus.rf_data, bus.mc_ready); end
    bus.mc_addr = 4'd6; bus.mc_data = 24'hF00005;
    tick();
    checks++; if (bus.rf_addr !== 4'd2 || bus.rf_data !== 24'hF00001 || bus.mc_ready !== 1'b1) begin
      errors++; $display("FAIL full_push_pop got %h/%h rdy=%b exp 2/f00001 1", bus.rf_addr, bus.rf_data, bus.mc_ready); end
    bus.pipe_we = 1'b1; bus.mc_addr = 4'd7; bus.mc_data = 24'hF00006;
    tick();
    checks++; if (bus.mc_ready !== 1'b0) begin errors++; $display("FAIL full_refill got %b exp 0", bus.mc_ready); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.rf_we !== 1'b1 || bus.rf_addr !== ea[i] || bus.rf_data !== ed[i]) begin
        errors++; $display("FAIL full_order_%0d got we=%b %h/%h exp 1 %h/%h", i, bus.rf_we, bus.rf_addr, bus.rf_data, ea[i], ed[i]); end
    end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL full_empty got %b exp 0", bus.rf_we); end
  endtask

  task automatic test_same_reg();
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = 4'd2; tick();
    idle(); bus.mc_valid = 1'b1; bus.mc_addr = 4'd2; bus.mc_data = 24'h222222; tick();
    idle(); bus.issue_valid = 1'b1; bus.issue_addr = 4'd2; tick();
    idle();
    checks++; if (bus.rf_addr !== 4'd2 || bus.pending[2] !== 1'b1) begin
      errors++; $display("FAIL same_reg_set_wins got addr=%h pend2=%b exp 2/1", bus.rf_addr, bus.pending[2]); end
    bus.mc_valid = 1'b1; bus.mc_addr = 4'd2; bus.mc_data = 24'h222223; tick();
    idle(); tick();
    checks++; if (bus.pending[2] !== 1'b0) begin errors++; $display("FAIL same_reg_clear got %b exp 0", bus.pending[2]); end
  endtask

  task automatic test_collision();
    idle();
    checks++; if (bus.err_collision !== 1'b0) begin errors++; $display("FAIL coll_initial got %b exp 0", bus.err_collision); end
    bus.mc_valid = 1'b1; bus.mc_addr = 4'd11; bus.mc_data = 24'hBBBBBB; tick();
    idle();
    for (int k = 0; k < SMAX; k++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = 4'd12; bus.pipe_data = DW'(k); tick();
    end
    checks++; if (bus.pipe_hold !== 1'b1) begin errors++; $display("FAIL coll_hold got %b exp 1", bus.pipe_hold); end
    bus.pipe_data = 24'hC0FFEE;
    tick();
    checks++; if (bus.err_collision !== 1'b1 || bus.rf_data !== 24'hC0FFEE) begin
      errors++; $display("FAIL coll_set got err=%b data=%h exp 1/c0ffee", bus.err_collision, bus.rf_data); end
    idle(); tick(); tick();
    checks++; if (bus.err_collision !== 1'b1) begin errors++; $display("FAIL coll_sticky got %b exp 1", bus.err_collision); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (bus.err_collision !== 1'b0) begin errors++; $display("FAIL coll_rst got %b exp 0", bus.err_collision); end
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.pipe_we = 1'b1; bus.pipe_addr = AW'(i); bus.pipe_data = DW'($urandom);
      bus.mc_valid = 1'b1; bus.mc_addr = AW'(8 + i); bus.mc_data = DW'($urandom);
      bus.issue_valid = 1'b1; bus.issue_addr = AW'(8 + i);
      tick();
    end
    checks++; if (bus.pending !== 16'h0700 || bus.mc_ready !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got pend=%h rdy=%b exp 0700/1", bus.pending, bus.mc_ready); end
    rst = 1'b1; tick(); tick(); rst = 1'b0; idle();
    checks++; if (bus.rf_we !== 1'b0 || bus.pending !== 16'h0 || bus.mc_ready !== 1'b1 || bus.pipe_hold !== 1'b0) begin
      errors++; $display("FAIL rstmid_post got we=%b pend=%h rdy=%b hold=%b exp 0/0/1/0",
                         bus.rf_we, bus.pending, bus.mc_ready, bus.pipe_hold); end
    tick();
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rstmid_fifo_flushed got %b exp 0", bus.rf_we); end
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      bus.pipe_we   = ((c % 120) < 60) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 2) == 0);
      bus.pipe_addr = AW'($urandom);
      bus.pipe_data = DW'($urandom);
      bus.mc_valid  = ($urandom_range(0, 2) == 0);
      bus.mc_addr   = AW'($urandom);
      bus.mc_data   = DW'($urandom);
      bus.chk_a     = AW'($urandom);
      bus.chk_b     = AW'($urandom);
      bus.chk_d     = AW'($urandom);
      bus.issue_addr  = bus.chk_d;
      bus.issue_valid = !m_pend[bus.chk_d] && ($urandom_range(0, 3) == 0);
      #1;
      exp_stall = m_pend[bus.chk_a] | m_pend[bus.chk_b] | m_pend[bus.chk_d];
      checks++; if (bus.stall !== exp_stall || bus.mc_ready !== (q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_comb_%0d got stall=%b rdy=%b exp %b/%b", c, bus.stall, bus.mc_ready, exp_stall, (q.size() < DEPTH)); end
      tick();
      checks++; if (bus.rf_we !== m_we || bus.rf_addr !== m_addr || bus.rf_data !== m_data) begin
        errors++; $display("FAIL rnd_rf_%0d got %b %h/%h exp %b %h/%h", c, bus.rf_we, bus.rf_addr, bus.rf_data, m_we, m_addr, m_data); end
      checks++; if (bus.pending !== m_pend || bus.pipe_hold !== m_hold || bus.err_collision !== m_err) begin
        errors++; $display("FAIL rnd_state_%0d got pend=%h hold=%b err=%b exp %h/%b/%b",
                           c, bus.pending, bus.pipe_hold, bus.err_collision, m_pend, m_hold, m_err); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_pipe_only();
    test_multicycle();
    test_conflict();
    test_starvation();
    test_full();
    test_same_reg();
    test_collision();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
